chan_mux_seq: RTL and testbench
===============================

// Module: chan_mux_seq
// PURPOSE
//  Parametrised NCH-channel, WIDTH-bit registered multiplexer. Successor to the 4:1 single-bit mux.
//  Two selection modes:
//   - manual: select is loaded from a port.
//   - scan: a dwell counter steps through the channels round-robin.
//  Sits between channel sources (sensors, test-pattern generators) and a single downstream consumer.
// PARAMETERS
//  WIDTH  8  data bits per channel
//  NCH    4  number of input channels (2..16)
//  SELW   2  select width; must satisfy 2**SELW >= NCH
//  DWELL  4  cycles spent on each channel in scan mode (>=1)
// PORTS
//  clk        in   1           single clock; all state updates on rising edge
//  rst        in   1           synchronous, active-high reset
//  in_data    in   NCH*WIDTH   channel k at bits [k*WIDTH +: WIDTH]
//  mode       in   1           0 = manual, 1 = scan
//  sel_in     in   SELW        requested channel (manual load)
//  sel_load   in   1           load sel_in into select register this cycle
//  hold       in   1           freeze outputs and dwell counter
//  out_data   out  WIDTH       registered selected data
//  out_sel    out  SELW        channel index that out_data came from
//  out_valid  out  1           out_data is meaningful
//  sel_err    out  1           1-cycle pulse: sel_load with sel_in >= NCH
//  scan_wrap  out  1           1-cycle pulse: scan stepped from NCH-1 to 0
// BEHAVIOUR
//  Reset values (rst=1 at an edge):
//   - select register S = 0, dwell counter D = 0
//   - out_data = 0, out_sel = 0, out_valid = 0, sel_err = 0, scan_wrap = 0
//  Datapath, each edge with hold=0:
//   - out_data <= in_data[S], out_sel <= S, out_valid <= 1
//   - 1-cycle latency from in_data or S to out_data; out_sel is always aligned with out_data
//  hold=1:
//   - out_data, out_sel, out_valid, S and D keep their values
//   - sel_err and scan_wrap are forced to 0
//   - a sel_load while hold=1 is ignored
//  Manual mode, sel_load=1:
//   - sel_in < NCH: S <= sel_in; D <= 0
//   - sel_in >= NCH: S is unchanged; sel_err <= 1 for one cycle
//  Scan mode (mode=1):
//   - each non-hold edge: D <= D+1
//   - when D == DWELL-1: D <= 0 and S <= (S == NCH-1) ? 0 : S+1
//   - on the NCH-1 -> 0 step, scan_wrap <= 1 for one cycle
//   - D never exceeds DWELL-1
//  Priority on the same edge: rst > hold > sel_load > scan step.
//   - a valid sel_load in scan mode overrides the step and restarts dwell at the loaded channel
//  Mode change: D <= 0 on any edge where mode differs from its value at the previous edge; S is kept.
//   - scan resumes from the current channel with a full dwell
//  Manual mode with no sel_load: S and D are static.
//  Reset mid-scan: all state returns to reset values at that edge; out_valid is 0 for exactly one cycle.
// CONFIGURATION
//  MUX_PARITY_EN defined:
//   - adds output out_parity (1 bit) = ^out_data
//   - registered in the same cycle as out_data, reset 0, frozen by hold
//  MUX_PARITY_EN undefined:
//   - out_parity port and its logic are absent; all other behaviour is identical
// TESTING  (WIDTH=8, NCH=4, DWELL=4; d0=0x11, d1=0x22, d2=0x33, d3=0x44)
//  1. Reset, then manual load sel_in=0,1,2,3 (one per 10 cycles)
//     -> out_data 0x11/0x22/0x33/0x44 one cycle after each load; out_sel matches
//  2. Manual sel_in=5 with sel_load
//     -> sel_err=1 for 1 cycle; out_sel and out_data unchanged
//  3. Scan mode from S=0 for 16 cycles
//     -> each channel for 4 cycles in order 0,1,2,3
//     -> scan_wrap=1 exactly once, on the 3->0 step
//  4. Scan mode, hold=1 for 5 cycles mid-dwell
//     -> outputs frozen, no step
//     -> after release the remaining dwell completes before the next step
//  5. Scan mode, sel_load sel_in=2 on the same edge as a step 0->1
//     -> S=2, D restarts; out_sel=2 next cycle
//  6. rst during scan at S=3
//     -> next cycle out_data=0, out_valid=0, out_sel=0
//     -> following cycle out_data=0x11, out_valid=1
//     -> with MUX_PARITY_EN: out_parity=0 for 0x11 and 1 for 0x13

Source files
------------

// File: rtl/chan_mux_seq.sv
// NCH-channel registered multiplexer with manual select and round-robin scan.
// Define MUX_PARITY_EN to add the registered out_parity output.

module chan_mux_lane #(
    parameter int WIDTH = 8,
    parameter int SELW  = 2,
    parameter int IDX   = 0
) (
    input  logic [SELW-1:0]  i_sel,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_gated
);
    assign o_gated = (i_sel == SELW'(IDX)) ? i_data : '0;
endmodule

module chan_mux_seq #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = 2,
    parameter int DWELL = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel_in,
    input  logic                 sel_load,
    input  logic                 hold,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_sel,
    output logic                 out_valid,
    output logic                 sel_err,
    output logic                 scan_wrap
`ifdef MUX_PARITY_EN
    ,
    output logic                 out_parity
`endif
);
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0]   D_LAST = DW'(DWELL - 1);
    localparam logic [SELW-1:0] S_LAST = SELW'(NCH - 1);
    localparam int unsigned     NCH_U  = NCH;

    logic [SELW-1:0]              r_sel;
    logic [DW-1:0]                r_dwell;
    logic                         r_mode_prev;
    logic [NCH-1:0][WIDTH-1:0]    w_chan;
    logic [NCH-1:0][WIDTH-1:0]    w_gated;
    logic [WIDTH-1:0]             w_sel_data;
    logic                         w_load_ok;
    logic                         w_load_bad;
    logic                         w_mode_chg;

    assign w_chan = in_data;

    // One-hot gated lanes OR-reduced: select values >= NCH can never reach r_sel.
    for (genvar k = 0; k < NCH; k++) begin : g_lane
        chan_mux_lane #(.WIDTH(WIDTH), .SELW(SELW), .IDX(k)) u_lane (
            .i_sel   (r_sel),
            .i_data  (w_chan[k]),
            .o_gated (w_gated[k])
        );
    end

    always_comb begin
        w_sel_data = '0;
        for (int k = 0; k < NCH; k++) w_sel_data = w_sel_data | w_gated[k];
    end

    assign w_load_ok  = sel_load && (32'(sel_in) < NCH_U);
    assign w_load_bad = sel_load && !w_load_ok;
    assign w_mode_chg = (mode != r_mode_prev);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel       <= '0;
            r_dwell     <= '0;
            r_mode_prev <= 1'b0;
            out_data    <= '0;
            out_sel     <= '0;
            out_valid   <= 1'b0;
            sel_err     <= 1'b0;
            scan_wrap   <= 1'b0;
`ifdef MUX_PARITY_EN
            out_parity  <= 1'b0;
`endif
        end else begin
            r_mode_prev <= mode;
            sel_err     <= 1'b0;
            scan_wrap   <= 1'b0;
            if (!hold) begin
                out_data  <= w_sel_data;
                out_sel   <= r_sel;
                out_valid <= 1'b1;
`ifdef MUX_PARITY_EN
                out_parity <= ^w_sel_data;
`endif
                sel_err   <= w_load_bad;
                // A valid load beats a mode change, which beats the scan step.
                if (w_load_ok) begin
                    r_sel   <= sel_in;
                    r_dwell <= '0;
                end else if (w_mode_chg) begin
                    r_dwell <= '0;
                end else if (mode) begin
                    if (r_dwell == D_LAST) begin
                        r_dwell   <= '0;
                        r_sel     <= (r_sel == S_LAST) ? '0 : r_sel + SELW'(1);
                        scan_wrap <= (r_sel == S_LAST);
                    end else begin
                        r_dwell <= r_dwell + DW'(1);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_chan_mux_seq.sv
// Scoreboard bench for chan_mux_seq: expected outputs queued per driven cycle.
// Checks out_parity as well when MUX_PARITY_EN is defined.

module tb_chan_mux_seq;
    localparam int WIDTH = 8;
    localparam int NCH   = 4;
    localparam int SELW  = 3;
    localparam int DWELL = 4;

    logic                 clk = 1'b0;
    logic                 rst, mode, sel_load, hold;
    logic [SELW-1:0]      sel_in;
    logic [NCH*WIDTH-1:0] in_data;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_sel;
    logic                 out_valid, sel_err, scan_wrap;
`ifdef MUX_PARITY_EN
    logic                 out_parity;
`endif

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic [SELW-1:0]  s;
        logic             v;
        logic             e;
        logic             w;
    } exp_t;

    exp_t       sbq[$];
    exp_t       obs, ev;
    logic [7:0] chd [NCH];
    int         n_tests = 0;
    int         n_fail  = 0;

    assign in_data = {chd[3], chd[2], chd[1], chd[0]};
    assign obs     = {out_data, out_sel, out_valid, sel_err, scan_wrap};

    always #5 clk = ~clk;

    chan_mux_seq #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW), .DWELL(DWELL)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .mode      (mode),
        .sel_in    (sel_in),
        .sel_load  (sel_load),
        .hold      (hold),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .sel_err   (sel_err),
        .scan_wrap (scan_wrap)
`ifdef MUX_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int s_after(int m);
        return (m == 0) ? 0 : ((m - 1) / DWELL) % NCH;
    endfunction

    task automatic test_reset;
        rst = 1'b1; mode = 1'b0; sel_load = 1'b0; hold = 1'b0; sel_in = '0;
        sbq.push_back('{8'h00, 3'd0, 1'b0, 1'b0, 1'b0});
        tick;
        ev = sbq.pop_front();
        n_tests++;
        if (obs !== ev) begin
            n_fail++;
            $display("FAIL reset: got %p want %p", obs, ev);
        end
`ifdef MUX_PARITY_EN
        n_tests++;
        if (out_parity !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_parity: got %b want 0", out_parity);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_manual;
        int prev = 0;
        for (int k = 0; k < NCH; k++) begin
            for (int j = 0; j < 10; j++) begin
                sel_load = (j == 0);
                sel_in   = 3'(k);
                if (j == 0) sbq.push_back('{chd[prev], 3'(prev), 1'b1, 1'b0, 1'b0});
                else        sbq.push_back('{chd[k], 3'(k), 1'b1, 1'b0, 1'b0});
                tick;
                ev = sbq.pop_front();
                n_tests++;
                if (obs !== ev) begin
                    n_fail++;
                    $display("FAIL manual ch%0d cyc%0d: got %p want %p", k, j, obs, ev);
                end
            end
            prev = k;
        end
        sel_load = 1'b0;
    endtask

    task automatic test_sel_err;
        for (int j = 0; j < 3; j++) begin
            sel_load = (j == 0);
            sel_in   = 3'd5;
            sbq.push_back('{chd[3], 3'd3, 1'b1, (j == 0), 1'b0});
            tick;
            ev = sbq.pop_front();
            n_tests++;
            if (obs !== ev) begin
                n_fail++;
                $display("FAIL sel_err cyc%0d: got %p want %p", j, obs, ev);
            end
        end
        sel_load = 1'b0;
    endtask

    task automatic test_scan;
        int wraps = 0;
        logic w;
        int c;
        for (int m = 0; m <= 20; m++) begin
            mode     = (m != 0);
            sel_load = (m == 0);
            sel_in   = 3'd0;
            if (m == 0) begin
                sbq.push_back('{chd[3], 3'd3, 1'b1, 1'b0, 1'b0});
            end else begin
                c = s_after(m - 1);
                w = (m > DWELL) && ((m - 1) % DWELL == 0) && (s_after(m) == 0);
                sbq.push_back('{chd[c], 3'(c), 1'b1, 1'b0, w});
            end
            tick;
            if (scan_wrap === 1'b1) wraps++;
            ev = sbq.pop_front();
            n_tests++;
            if (obs !== ev) begin
                n_fail++;
                $display("FAIL scan edge%0d: got %p want %p", m, obs, ev);
            end
        end
        sel_load = 1'b0;
        n_tests++;
        if (wraps != 1) begin
            n_fail++;
            $display("FAIL scan_wrap_count: got %0d want 1", wraps);
        end
    endtask

    task automatic test_hold;
        int c;
        for (int i = 0; i < 14; i++) begin
            mode     = (i >= 2);
            hold     = (i >= 4 && i <= 8);
            sel_load = (i == 0 || i == 5 || i == 6);
            sel_in   = (i == 0) ? 3'd1 : (i == 5) ? 3'd5 : 3'd3;
            chd[1]   = (i >= 4 && i <= 8) ? 8'h99 : 8'h22;
            c = (i == 0) ? 0 : (i >= 12) ? 2 : 1;
            sbq.push_back('{(c == 1) ? 8'h22 : chd[c], 3'(c), 1'b1, 1'b0, 1'b0});
            tick;
            ev = sbq.pop_front();
            n_tests++;
            if (obs !== ev) begin
                n_fail++;
                $display("FAIL hold step%0d: got %p want %p", i, obs, ev);
            end
        end
        hold = 1'b0; sel_load = 1'b0; chd[1] = 8'h22;
    endtask

    task automatic test_load_over_step;
        int c;
        for (int i = 0; i <= 10; i++) begin
            mode     = (i != 0);
            sel_load = (i == 0 || i == 5);
            sel_in   = (i == 0) ? 3'd0 : 3'd2;
            c = (i == 0) ? 2 : (i <= 5) ? 0 : (i <= 9) ? 2 : 3;
            sbq.push_back('{chd[c], 3'(c), 1'b1, 1'b0, 1'b0});
            tick;
            ev = sbq.pop_front();
            n_tests++;
            if (obs !== ev) begin
                n_fail++;
                $display("FAIL load_over_step edge%0d: got %p want %p", i, obs, ev);
            end
        end
        sel_load = 1'b0;
    endtask

    task automatic test_reset_mid_scan;
        logic par;
        for (int j = 0; j < 3; j++) begin
            rst    = (j == 0);
            chd[0] = (j == 2) ? 8'h13 : 8'h11;
            if (j == 0)      sbq.push_back('{8'h00, 3'd0, 1'b0, 1'b0, 1'b0});
            else if (j == 1) sbq.push_back('{8'h11, 3'd0, 1'b1, 1'b0, 1'b0});
            else             sbq.push_back('{8'h13, 3'd0, 1'b1, 1'b0, 1'b0});
            par = (j == 2);
            tick;
            ev = sbq.pop_front();
            n_tests++;
            if (obs !== ev) begin
                n_fail++;
                $display("FAIL reset_mid_scan cyc%0d: got %p want %p", j, obs, ev);
            end
`ifdef MUX_PARITY_EN
            n_tests++;
            if (out_parity !== par) begin
                n_fail++;
                $display("FAIL parity cyc%0d: got %b want %b", j, out_parity, par);
            end
`endif
        end
        rst = 1'b0; chd[0] = 8'h11;
    endtask

    initial begin
        chd[0] = 8'h11; chd[1] = 8'h22; chd[2] = 8'h33; chd[3] = 8'h44;
        rst = 1'b1; mode = 1'b0; sel_load = 1'b0; hold = 1'b0; sel_in = '0;
        test_reset;
        test_manual;
        test_sel_err;
        test_scan;
        test_hold;
        test_load_over_step;
        test_reset_mid_scan;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
